// File: rtl/cla_iter_adder_pkg.sv
// Shared definitions for the iterative carry-lookahead adder: FSM encodings,
// slice width and the 4-bit lookahead carry helpers.
package cla_iter_adder_pkg;

    localparam int SLICE_W = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Lookahead carries {c3,c2,c1,c0} for a 4-wide group of propagate/generate pairs.
    function automatic logic [3:0] lcu4(input logic [3:0] p, input logic [3:0] g, input logic c0);
        logic [3:0] c;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
        return c;
    endfunction

    function automatic logic grp_g(input logic [3:0] p, input logic [3:0] g);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    endfunction

endpackage

// File: rtl/cla_iter_adder_if.sv
// Request/result bundle between the iterative adder and its consumer.
interface cla_iter_adder_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (output start, sub, cin, a, b, input busy, done, sum, cout, ovf);
    modport slave  (input start, sub, cin, a, b, output busy, done, sum, cout, ovf);
endinterface

// File: rtl/cla_iter_adder_cla16.sv
// 16-bit carry-lookahead slice: four 4-bit P/G groups feeding a 4-bit LCU.
module cla16
    import cla_iter_adder_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] s,
    output logic        cout,
    output logic        c15
);
    logic [15:0] p;
    logic [15:0] g;
    logic [15:0] c;
    logic [3:0]  gp;
    logic [3:0]  gg;
    logic [3:0]  gc;

    assign p = a ^ b;
    assign g = a & b;

    for (genvar i = 0; i < 4; i++) begin : g_grp
        assign gp[i]      = &p[4*i +: 4];
        assign gg[i]      = grp_g(p[4*i +: 4], g[4*i +: 4]);
        assign c[4*i +: 4] = lcu4(p[4*i +: 4], g[4*i +: 4], gc[i]);
    end

    // Slice carry-out uses the block generate/propagate form, not a ripple from group 3.
    assign gc   = lcu4(gp, gg, cin);
    assign cout = grp_g(gp, gg) | ((&gp) & cin);
    assign s    = p ^ c;
    assign c15  = c[15];

endmodule

// File: rtl/cla_iter_adder.sv
// Multi-cycle wide add/subtract: one cla16 slice per cycle, LSB-first, with a
// registered carry chaining the slices.
//
//  state   | meaning
//  --------+-------------------------------------------------
//  IDLE    | waiting for start; operands captured on accept
//  RUN     | one 16-bit slice per cycle, slice index k
//  DONE    | one-cycle done pulse, inputs ignored
module cla_iter_adder
    import cla_iter_adder_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input logic              clk,
    input logic              rst,
    cla_iter_adder_if.slave  bus
);
    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

    logic [1:0]       state;
    logic [KW-1:0]    k;
    logic [KW+3:0]    base;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;
    logic [15:0]      sl_s;
    logic             sl_cout;
    logic             sl_c15;

    assign base = {k, 4'b0000};

    cla16 u_cla16 (
        .a    (op_a[base +: SLICE_W]),
        .b    (op_b[base +: SLICE_W]),
        .cin  (carry),
        .s    (sl_s),
        .cout (sl_cout),
        .c15  (sl_c15)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            k      <= '0;
            carry  <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_a  <= bus.a;
                        op_b  <= bus.sub ? ~bus.b : bus.b;
                        carry <= bus.sub | bus.cin;
                        k     <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum_r[base +: SLICE_W] <= sl_s;
                    carry                  <= sl_cout;
                    if (k == K_LAST) begin
                        cout_r <= sl_cout;
                        ovf_r  <= sl_c15 ^ sl_cout;
                        state  <= ST_DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = (state == ST_RUN) || (state == ST_DONE);
    assign bus.done = (state == ST_DONE);
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;

endmodule
